// File: rtl/cpu_control_unit.sv
// Multicycle FSM control unit for the 8-bit CPU (fetch/decode/execute/mem/write-back).
// Optional: define CU_PC_END_HALT_EN to halt after the instruction fetched at pc==31.
module cpu_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic       zero_flag,
  input  logic [4:0] pc,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_src,
  output logic [1:0] reg_dest,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src1,
  output logic [1:0] alu_src2,
  output logic       imm_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_addr_src
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_LOAD,
    OP_STORE,
    OP_JMP,
    OP_JZ,
    OP_HALT
  } opcode_e;

  state_e  state_q, state_d;
  logic    end_q, end_d;
  opcode_e opcode;
  logic    is_alu;
  logic    pc_at_end;
  state_e  done_state;

  assign opcode = opcode_e'(instruction[7:5]);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

`ifdef CU_PC_END_HALT_EN
  assign pc_at_end = (pc == 5'd31);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign pc_at_end = 1'b0;
`endif

  // Where a completed instruction goes: HALT once the last PC slot has been fetched.
  assign done_state = end_q ? ST_HALT : ST_FETCH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    end_d   = end_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_DECODE;
        if (pc_at_end) end_d = 1'b1;
      end
      ST_DECODE: begin
        case (opcode)
          OP_HALT:           state_d = ST_HALT;
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          default:           state_d = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        if (is_alu) begin
          state_d = ST_WRITEBACK;
        end else if (opcode == OP_JMP || (opcode == OP_JZ && zero_flag)) begin
          // A taken branch leaves the end of memory, so normal fetching resumes.
          state_d = ST_FETCH;
          end_d   = 1'b0;
        end else begin
          state_d = done_state;
        end
      end
      ST_MEM: begin
        if (opcode == OP_LOAD) state_d = ST_WRITEBACK;
        else                   state_d = done_state;
      end
      ST_WRITEBACK: state_d = done_state;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_src      = 1'b0;
    reg_dest     = '0;
    alu_op       = '0;
    alu_src1     = '0;
    alu_src2     = '0;
    imm_sel      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_src = 1'b0;
    // Gated by reset so outputs drop the moment reset rises, not at the next edge.
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = 1'b1;
          pc_write = !pc_at_end;
        end
        ST_DECODE: begin
          if (is_alu) begin
            alu_src1 = instruction[3:2];
            alu_src2 = instruction[1:0];
          end
        end
        ST_EXECUTE: begin
          if (is_alu) begin
            alu_op   = instruction[6:5];
            alu_src1 = instruction[3:2];
            alu_src2 = instruction[1:0];
            imm_sel  = instruction[4];
          end else if (opcode == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end else if (opcode == OP_JZ) begin
            pc_write = zero_flag;
            pc_src   = 1'b1;
          end
        end
        ST_MEM: begin
          mem_addr_src = 1'b1;
          if (opcode == OP_LOAD) mem_read  = 1'b1;
          else                   mem_write = 1'b1;
        end
        ST_WRITEBACK: begin
          reg_write = 1'b1;
          if (is_alu) begin
            reg_dest = instruction[3:2];
            alu_op   = instruction[6:5];
            alu_src1 = instruction[3:2];
            alu_src2 = instruction[1:0];
            imm_sel  = instruction[4];
          end else begin
            reg_src = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: per-instruction expected strobe sequences.
// Define CU_PC_END_HALT_EN for both bench and RTL to exercise end-of-memory halting.
module tb_cpu_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       psrc;
    logic       irw;
    logic       regw;
    logic       rsrc;
    logic [1:0] rdest;
    logic [1:0] aop;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       imm;
    logic       memr;
    logic       memw;
    logic       mema;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instruction;
  logic       zero_flag;
  logic [4:0] pc;
  logic       pc_write, pc_src, ir_write, reg_write, reg_src;
  logic [1:0] reg_dest, alu_op, alu_src1, alu_src2;
  logic       imm_sel, mem_read, mem_write, mem_addr_src;

  ctl_t act;
  assign act = {pc_write, pc_src, ir_write, reg_write, reg_src, reg_dest, alu_op,
                alu_src1, alu_src2, imm_sel, mem_read, mem_write, mem_addr_src};

  int   n_cmp = 0;
  int   n_bad = 0;
  ctl_t exp_q[$];
  bit   exp_halt;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero_flag(zero_flag), .pc(pc),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .reg_src(reg_src), .reg_dest(reg_dest), .alu_op(alu_op), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .imm_sel(imm_sel), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_src(mem_addr_src)
  );

  function automatic ctl_t fetch_vec(input bit pcw);
    ctl_t v = '0;
    v.memr = 1'b1;
    v.irw  = 1'b1;
    v.pcw  = pcw;
    return v;
  endfunction

  function automatic bit end_slot(input logic [4:0] p);
`ifdef CU_PC_END_HALT_EN
    return p == 5'd31;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: the cycle-by-cycle strobe list an instruction must produce, from FETCH on.
  task automatic build_expected(input logic [7:0] ins, input bit zf, input bit at_end);
    ctl_t v;
    bit   endf = at_end;
    int unsigned op = ins[7:5];
    exp_q.delete();
    exp_q.push_back(fetch_vec(!at_end));
    v = '0;
    if (op <= 2) begin
      v.s1 = ins[3:2];
      v.s2 = ins[1:0];
    end
    exp_q.push_back(v);
    case (op)
      0, 1, 2: begin
        v.aop = 2'(op);
        v.imm = ins[4];
        exp_q.push_back(v);
        v.regw  = 1'b1;
        v.rdest = ins[3:2];
        exp_q.push_back(v);
      end
      3: begin
        v = '0; v.memr = 1'b1; v.mema = 1'b1; exp_q.push_back(v);
        v = '0; v.regw = 1'b1; v.rsrc = 1'b1; exp_q.push_back(v);
      end
      4: begin
        v = '0; v.memw = 1'b1; v.mema = 1'b1; exp_q.push_back(v);
      end
      5: begin
        v = '0; v.pcw = 1'b1; v.psrc = 1'b1; exp_q.push_back(v);
        endf = 1'b0;
      end
      6: begin
        v = '0; v.pcw = zf; v.psrc = 1'b1; exp_q.push_back(v);
        if (zf) endf = 1'b0;
      end
      default: endf = 1'b1;
    endcase
    exp_halt = endf;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (act !== ctl_t'('0)) begin
      n_bad++;
      $display("FAIL %s: outputs got=%h want=00000", tag, act);
    end
  endtask

  // Entered at a time where the DUT sits in FETCH; leaves it in the next FETCH.
  task automatic run_instr(input logic [7:0] ins, input bit zf, input logic [4:0] pcv,
                           input string tag);
    instruction = ins;
    zero_flag   = zf;
    pc          = pcv;
    build_expected(ins, zf, end_slot(pcv));
    foreach (exp_q[i]) begin
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s ins=%h cyc=%0d: got=%h want=%h", tag, ins, i, act, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    if (exp_halt) begin
      for (int k = 0; k < 3; k++) begin
        instruction = 8'($urandom);
        zero_flag   = 1'($urandom);
        #1 check_zero({tag, "_halted"});
        @(posedge clk); #1;
      end
      reset = 1'b1;
      #1 check_zero({tag, "_halt_reset"});
      @(negedge clk);
      reset = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instruction = 8'h06;
    zero_flag = 1'b0;
    pc = 5'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      instruction = 8'($urandom);
      pc = 5'($urandom_range(30, 0));
      #1 check_zero("reset_hold");
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (act !== fetch_vec(1'b1)) begin
      n_bad++;
      $display("FAIL reset_release: got=%h want=%h", act, fetch_vec(1'b1));
    end
  endtask

  task automatic test_directed;
    run_instr(8'h06, 1'b0, 5'd0, "add_r1_r2");
    run_instr(8'h64, 1'b0, 5'd1, "load");
    run_instr(8'h83, 1'b0, 5'd2, "store");
    run_instr(8'hA2, 1'b0, 5'd3, "jmp");
    run_instr(8'hD5, 1'b1, 5'd2, "jz_taken");
    run_instr(8'hD5, 1'b0, 5'd3, "jz_not_taken");
    run_instr(8'h3F, 1'b0, 5'd4, "sub_imm");
    run_instr(8'h5B, 1'b1, 5'd5, "and_regs");
  endtask

  task automatic test_jz_live;
    instruction = 8'hD5;
    zero_flag   = 1'b0;
    pc          = 5'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (pc_write !== 1'b0 || pc_src !== 1'b1) begin
      n_bad++;
      $display("FAIL jz_live_zf0: got pcw=%b psrc=%b want pcw=0 psrc=1", pc_write, pc_src);
    end
    zero_flag = 1'b1;
    #1;
    n_cmp++;
    if (pc_write !== 1'b1 || pc_src !== 1'b1) begin
      n_bad++;
      $display("FAIL jz_live_zf1: got pcw=%b psrc=%b want pcw=1 psrc=1", pc_write, pc_src);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (act !== fetch_vec(1'b1)) begin
      n_bad++;
      $display("FAIL jz_live_next: got=%h want=%h", act, fetch_vec(1'b1));
    end
  endtask

  task automatic test_reset_mid;
    instruction = 8'h06;
    zero_flag   = 1'b0;
    pc          = 5'd9;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check_zero("reset_mid_exec");
    @(posedge clk); #1;
    check_zero("reset_mid_hold");
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (act !== fetch_vec(1'b1)) begin
      n_bad++;
      $display("FAIL reset_mid_release: got=%h want=%h", act, fetch_vec(1'b1));
    end
  endtask

  task automatic test_halt;
    run_instr(8'hE0, 1'b0, 5'd10, "halt");
    run_instr(8'h06, 1'b0, 5'd0, "after_halt");
  endtask

  task automatic test_random;
    logic [7:0] ins;
    for (int n = 0; n < 300; n++) begin
      ins = 8'($urandom);
      if (ins[7:5] == 3'd7 && $urandom_range(3, 0) != 0) ins[7:5] = 3'($urandom_range(6, 0));
      run_instr(ins, 1'($urandom), 5'($urandom_range(30, 0)), "random");
    end
  endtask

  task automatic test_pc_end;
`ifdef CU_PC_END_HALT_EN
    run_instr(8'h00, 1'b0, 5'd31, "end_add");
    run_instr(8'hA2, 1'b0, 5'd31, "end_jmp");
    run_instr(8'h06, 1'b0, 5'd0,  "end_jmp_next");
    run_instr(8'hD5, 1'b0, 5'd31, "end_jz_nt");
    run_instr(8'hD5, 1'b1, 5'd31, "end_jz_t");
    run_instr(8'h64, 1'b0, 5'd31, "end_load");
    run_instr(8'h83, 1'b0, 5'd31, "end_store");
`endif
    run_instr(8'h06, 1'b0, 5'd31, "wrap_add");
    run_instr(8'h06, 1'b0, 5'd0,  "wrap_next");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_jz_live;
    test_reset_mid;
    test_halt;
    test_pc_end;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
